// File: rtl/addbit_serial_n_if.sv
// Operand/result handshake bundle for the digit-serial adder.
// master drives operands and result acceptance; slave is the adder.
interface addbit_serial_n_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );
endinterface

// File: rtl/addbit_serial_n.sv
// Digit-serial add/subtract, DIGIT bits per cycle, LSB slice first.
// Result valid WIDTH/DIGIT cycles after accept; holds in DONE until out_ready, one op in flight.
module addbit_serial_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    addbit_serial_n_if.slave bus
);
    localparam int DSAFE = (DIGIT < 1) ? 1 : DIGIT;
    localparam int N     = WIDTH / DSAFE;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DSAFE) != 0) begin : g_bad_param
            $error("addbit_serial_n: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             co_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             last;
    logic [DIGIT-1:0] a_sl;
    logic [DIGIT-1:0] b_sl;
    logic [DIGIT:0]   sl_sum;
    logic [DIGIT-1:0] s_sl;
    logic             c_sl;
    logic             cin_msb;
    logic [WIDTH+DIGIT-1:0] sum_cat;

    assign accept = bus.in_valid && (state == IDLE);
    assign last   = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slice adder; carry into the top bit is recovered from the sum bit so ovf needs no extra adder.
    always_comb begin
        a_sl    = a_q[DIGIT-1:0];
        b_sl    = b_q[DIGIT-1:0];
        sl_sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry_q};
        s_sl    = sl_sum[DIGIT-1:0];
        c_sl    = sl_sum[DIGIT];
        cin_msb = s_sl[DIGIT-1] ^ a_sl[DIGIT-1] ^ b_sl[DIGIT-1];
        sum_cat = {s_sl, sum_q} >> DIGIT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? ~bus.ci : bus.ci;
            cnt_q   <= '0;
        end else if (state == RUN) begin
            // Operands shift down, result shifts in from the top: after N slices sum is fully formed.
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            sum_q   <= sum_cat[WIDTH-1:0];
            carry_q <= c_sl;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                co_q  <= c_sl;
                ovf_q <= c_sl ^ cin_msb;
            end
        end
    end

    assign bus.sum = sum_q;
    assign bus.co  = co_q;
    assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_addbit_serial_n.sv
// Directed-vector bench for addbit_serial_n: DIGIT=2 and DIGIT=8 instances at WIDTH=8.
module tb_addbit_serial_n;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    int   lat;

    always #5 clk = ~clk;

    addbit_serial_n_if #(.WIDTH(8)) bus ();
    addbit_serial_n_if #(.WIDTH(8)) bus_w ();

    addbit_serial_n #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    addbit_serial_n #(.WIDTH(8), .DIGIT(8)) u_dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Accept one operation on the DIGIT=2 instance and check latency and result.
    task automatic op(input logic [7:0] va, input logic [7:0] vb, input logic vci, input logic vsub,
                      input logic [7:0] es, input logic eco, input logic eovf, input string tag);
        chk({tag, ".in_ready"}, bus.in_ready, 1);
        bus.a        = va;
        bus.b        = vb;
        bus.ci       = vci;
        bus.sub      = vsub;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, ".latency"}, lat, 4);
        chk({tag, ".sum"}, bus.sum, es);
        chk({tag, ".co"}, bus.co, eco);
        chk({tag, ".ovf"}, bus.ovf, eovf);
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, ".idle_in_ready"}, bus.in_ready, 1);
        chk({tag, ".idle_out_valid"}, bus.out_valid, 0);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.ci          = 1'b0;
        bus.sub         = 1'b0;
        bus.out_ready   = 1'b0;
        bus_w.in_valid  = 1'b0;
        bus_w.a         = '0;
        bus_w.b         = '0;
        bus_w.ci        = 1'b0;
        bus_w.sub       = 1'b0;
        bus_w.out_ready = 1'b0;
        step(2);

        chk("rst.in_ready", bus.in_ready, 1);
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.sum", bus.sum, 0);
        chk("rst.co", bus.co, 0);
        chk("rst.ovf", bus.ovf, 0);
        chk("rst_w.in_ready", bus_w.in_ready, 1);
        rst_n = 1'b1;
        step();

        op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");   drain("add_0f_01");
        op(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, "add_ff_01_c"); drain("add_ff_01_c");
        op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_ovf");     drain("add_ovf");
        op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_borrow");  drain("sub_borrow");
        op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_ovf");     drain("sub_ovf");
        op(8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, "sub_bin");     drain("sub_bin");

        // Hold in DONE with new operands offered; they must not be taken.
        op(8'h3C, 8'h0A, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "hold");
        bus.a        = 8'hFF;
        bus.b        = 8'hFF;
        bus.ci       = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold.sum", bus.sum, 8'h46);
            chk("hold.co", bus.co, 0);
            chk("hold.ovf", bus.ovf, 0);
            chk("hold.in_ready", bus.in_ready, 0);
            chk("hold.out_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        drain("hold");
        chk("hold.idle_sum", bus.sum, 8'h46);
        step(6);
        chk("hold.not_taken", bus.in_ready, 1);

        // Reset after two slices aborts the op.
        bus.a        = 8'h33;
        bus.b        = 8'h11;
        bus.ci       = 1'b0;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step(2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort.out_valid", bus.out_valid, 0);
        chk("abort.sum", bus.sum, 0);
        chk("abort.in_ready", bus.in_ready, 1);
        chk("abort.co", bus.co, 0);
        step(6);
        chk("abort.no_result", bus.out_valid, 0);
        op(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, "post_abort"); drain("post_abort");

        // Single-slice instance: DIGIT == WIDTH.
        chk("w.in_ready", bus_w.in_ready, 1);
        bus_w.a        = 8'hAA;
        bus_w.b        = 8'h55;
        bus_w.ci       = 1'b1;
        bus_w.sub      = 1'b0;
        bus_w.in_valid = 1'b1;
        step();
        bus_w.in_valid = 1'b0;
        lat = 0;
        while (!bus_w.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("w.latency", lat, 1);
        chk("w.sum", bus_w.sum, 8'h00);
        chk("w.co", bus_w.co, 1);
        chk("w.ovf", bus_w.ovf, 0);
        bus_w.out_ready = 1'b1;
        step();
        bus_w.out_ready = 1'b0;
        chk("w.idle_in_ready", bus_w.in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
